exhaustive_sweep_gen: RTL
=========================

Name: exhaustive_sweep_gen

Overview:
Synthesizable, parametrised exhaustive stimulus engine for combinational sub-blocks. It drives every input combination of an IN_W-bit DUT in binary or Gray order and waits a programmable settle time per vector. It samples the DUT outputs and folds them into a MISR signature, so a bench or on-chip self-test compares one word instead of a waveform dump. It sits between the top-level bench/BIST controller and the DUT input/output pins.

Parameters:
IN_W, 3, DUT input width; sweep length = 2**IN_W vectors (1..16).
OUT_W, 2, DUT output width captured per vector (1..SIG_W).
SETTLE, 1, clock cycles each vector is held before sampling (>=1).
SIG_W, 16, MISR signature width.
POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-high.
start  in  1  begin sweep; honoured only when not busy.
mode  in  1  0 = binary order, 1 = Gray order; latched on accepted start.
hold  in  1  freezes the sweep (all state held) while high.
dut_out  in  OUT_W  DUT outputs to sample.
vec_out  out  IN_W  vector driven to DUT inputs.
vec_idx  out  IN_W  sequence index of the current vector (binary).
sample_valid  out  1  one-cycle pulse on the sample cycle.
busy  out  1  sweep in progress.
done  out  1  sticky completion flag.
signature  out  SIG_W  MISR value.

Behaviour:
- Reset (rst high at edge): state IDLE; vec_out=0, vec_idx=0, sample_valid=0, busy=0, done=0, signature=0. Reset wins over every other input, including mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start: the next cycle is SETTLE; vec_idx=0, signature=0, done=0, busy=1, mode latched.
- start while busy: ignored; mode changes while busy: ignored.
- vec_out = vec_idx when latched mode=0; vec_out = vec_idx ^ (vec_idx>>1) when latched mode=1. It is registered alongside vec_idx, with no extra latency.
- SETTLE: a settle counter counts SETTLE cycles (including entry). After the last count the next state is SAMPLE.
- SAMPLE (one cycle): sample_valid=1.
  - At the closing edge: signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended dut_out.
  - If vec_idx == 2**IN_W-1, go to DONE. Otherwise vec_idx increments and the next state is SETTLE.
- Per-vector period is SETTLE+1 cycles; busy stays high for 2**IN_W*(SETTLE+1) cycles.
- DONE: busy=0, done=1 (sticky until the next accepted start or rst). vec_out and vec_idx hold the last vector; signature holds.
- hold=1: state, counters, vec_idx, vec_out and signature are frozen, and sample_valid is forced 0. A frozen SAMPLE cycle resumes as SAMPLE; the MISR updates exactly once per vector.
- hold has no effect in IDLE/DONE; start is still accepted there.
- vec_idx wrap: never wraps; the terminal index goes to DONE.

Test Plan:
- Reset mid-sweep: rst at vector 5 -> next cycle busy=0, done=0, vec_out=0, signature=0.
- Binary sweep, IN_W=3, SETTLE=1, start pulsed:
  - vec_out=0..7, each held 2 cycles.
  - busy high exactly 16 cycles, 8 sample_valid pulses.
  - done rises on the cycle busy falls.
- Gray sweep, mode=1: vec_out sequence is 0,1,3,2,6,7,5,4, and successive vectors differ in exactly one bit.
- Signature: dut_out tied 2'b01, binary sweep -> final signature=16'h00FF. dut_out tied 0 -> signature=16'h0000.
- hold asserted 3 cycles during a SAMPLE cycle -> sweep length becomes 19 cycles, still 8 sample_valid pulses, signature unchanged (16'h00FF with dut_out=2'b01).
- start while busy and mode toggled mid-sweep -> sequence and length unaffected. start in DONE -> done clears, signature reseeds to 0, new sweep runs.

Source files
------------

// File: rtl/exhaustive_sweep_gen.sv
// Exhaustive stimulus engine: walks every IN_W-bit input vector in binary or
// Gray order, holds each for SETTLE cycles, then folds the DUT response into
// a MISR signature.
module exhaustive_sweep_gen #(
   parameter int unsigned      IN_W   = 3,
   parameter int unsigned      OUT_W  = 2,
   parameter int unsigned      SETTLE = 1,
   parameter int unsigned      SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             hold,
   input  logic [OUT_W-1:0] dut_out,
   output logic [IN_W-1:0]  vec_out,
   output logic [IN_W-1:0]  vec_idx,
   output logic             sample_valid,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature
);

   localparam int unsigned    CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [IN_W-1:0]  idx_q, idx_d;
   logic [IN_W-1:0]  vec_q, vec_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic             mode_q, mode_d;
   logic [IN_W-1:0]  idx_inc;
   logic [SIG_W-1:0] sig_next;

   // Next index and its MISR-folded signature, used only on the sample cycle.
   always_comb begin
      idx_inc  = idx_q + IN_W'(1);
      sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(dut_out);
   end

   // Sweep sequencing; hold freezes everything while a sweep is in progress.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      vec_d        = vec_q;
      sig_d        = sig_q;
      mode_d       = mode_q;
      sample_valid = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StSettle;
               cnt_d   = '0;
               idx_d   = '0;
               vec_d   = '0;
               sig_d   = '0;
               mode_d  = mode;
            end
         end
         StSettle: begin
            if (!hold) begin
               if (cnt_q == CntLast) begin
                  state_d = StSample;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StSample: begin
            if (!hold) begin
               sample_valid = 1'b1;
               sig_d        = sig_next;
               if (idx_q == '1) begin
                  state_d = StDone;
               end else begin
                  state_d = StSettle;
                  cnt_d   = '0;
                  idx_d   = idx_inc;
                  // vec_out tracks vec_idx in the same cycle, so encode the next index here.
                  vec_d   = mode_q ? (idx_inc ^ (idx_inc >> 1)) : idx_inc;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         vec_q   <= '0;
         sig_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         sig_q   <= sig_d;
         mode_q  <= mode_d;
      end
   end

   // Status and data outputs decoded from registered state.
   always_comb begin
      busy      = (state_q == StSettle) || (state_q == StSample);
      done      = (state_q == StDone);
      vec_out   = vec_q;
      vec_idx   = idx_q;
      signature = sig_q;
   end

endmodule
